led_fade_ctrl: RTL and testbench

//  Upstream control stage for the PWM LED dimmer. Turns debounced button pulses into a brightness

---
 rtl/led_dim_pkg.sv | 28 ++
 rtl/led_tick_gen.sv | 36 +++
 rtl/led_fade_ctrl.sv | 141 ++++++++++++++
 tb/tb_led_fade_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/led_dim_pkg.sv
// ============================================================================
// Module      : led_dim_pkg
// Description : Shared types and helpers for the LED fade controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_dim_pkg;

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_RAMP = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   localparam int DEF_W_CNT = 16;

   function automatic int lvl_w(input int max_lvl);
      return (max_lvl < 1) ? 1 : $clog2(max_lvl + 1);
   endfunction

   function automatic int rst_lvl(input int max_lvl);
      return max_lvl / 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================================
// Module      : led_tick_gen
// Description : Free-running divider, registered 1-clk tick every DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_tick_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          tick_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= (cnt_q == LAST);
         cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/led_fade_ctrl.sv
// ============================================================================
// Module      : led_fade_ctrl
// Description : Button-driven brightness level with smooth PWM threshold ramp.
//               Define LED_FADE_GAMMA_EN for the quadratic level->duty curve.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_fade_ctrl
   import led_dim_pkg::*;
#(
   parameter int W_CNT    = DEF_W_CNT,
   parameter int MAX_LVL  = 15,
   parameter int LVL_STEP = 4096,
   parameter int FADE_DIV = 50000,
   parameter int PWM_DIV  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        btn_up,
   input  logic                        btn_dn,
   input  logic                        btn_pwr,
   input  logic [W_CNT-1:0]            period,
   output logic [W_CNT-1:0]            thr,
   output logic                        pwm_en,
   output logic [lvl_w(MAX_LVL)-1:0]   level,
   output logic                        busy
);

   localparam int LW       = lvl_w(MAX_LVL);
   localparam int STEP_W   = $clog2(LVL_STEP + 1);
   localparam int PROD_RAW = 2 * LW + STEP_W;
   localparam int PROD_W   = (PROD_RAW > W_CNT) ? PROD_RAW : W_CNT + 1;
   localparam logic [LW-1:0] LVL_MAX = LW'(MAX_LVL);
   localparam logic [LW-1:0] LVL_RST = LW'(rst_lvl(MAX_LVL));

   state_e            state_q;
   logic [LW-1:0]     level_q, level_d;
   logic [W_CNT-1:0]  cur_q, cur_step;
   logic              off_pend_q;
   logic              busy_q;
   logic              lvl_chg;
   logic [PROD_W-1:0] prod;
   logic [W_CNT-1:0]  tgt_on, tgt;
   logic              fade_tick, pwm_tick;

   led_tick_gen #(.DIV(FADE_DIV)) u_fade_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (fade_tick)
   );

   led_tick_gen #(.DIV(PWM_DIV)) u_pwm_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (pwm_tick)
   );

   // Full-width product first, then clamp to the current period.
   always_comb begin
`ifdef LED_FADE_GAMMA_EN
      prod = (PROD_W'(level_q) * PROD_W'(level_q) * PROD_W'(LVL_STEP)) >> LW;
`else
      prod = PROD_W'(level_q) * PROD_W'(LVL_STEP);
`endif
      tgt_on = (prod > PROD_W'(period)) ? period : prod[W_CNT-1:0];
      tgt    = off_pend_q ? '0 : tgt_on;
   end

   // pwr wins over up/dn; up+dn together cancel; saturated presses change nothing.
   always_comb begin
      level_d = level_q;
      if (!btn_pwr && !off_pend_q && (state_q != S_OFF)) begin
         if (btn_up && !btn_dn && (level_q != LVL_MAX))
            level_d = level_q + LW'(1);
         else if (btn_dn && !btn_up && (level_q != '0))
            level_d = level_q - LW'(1);
      end
      lvl_chg  = (level_d != level_q);
      cur_step = (cur_q < tgt) ? cur_q + W_CNT'(1) : cur_q - W_CNT'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_OFF;
         level_q    <= LVL_RST;
         cur_q      <= '0;
         off_pend_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         level_q <= level_d;
         case (state_q)
            S_OFF: begin
               if (btn_pwr) begin
                  state_q    <= S_RAMP;
                  busy_q     <= 1'b1;
                  off_pend_q <= 1'b0;
               end
            end
            S_RAMP: begin
               if (btn_pwr)
                  off_pend_q <= !off_pend_q;
               if (cur_q != tgt) begin
                  if (fade_tick)
                     cur_q <= cur_step;
               end else if (!btn_pwr && !lvl_chg) begin
                  busy_q <= 1'b0;
                  if (off_pend_q) begin
                     state_q    <= S_OFF;
                     off_pend_q <= 1'b0;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (btn_pwr) begin
                  state_q    <= S_RAMP;
                  off_pend_q <= 1'b1;
                  busy_q     <= 1'b1;
               end else if (lvl_chg || (cur_q != tgt)) begin
                  state_q <= S_RAMP;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_OFF;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign thr    = (cur_q > period) ? '0 : period - cur_q;
   assign pwm_en = pwm_tick && (state_q != S_OFF);
   assign level  = level_q;
   assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_ctrl.sv
// ============================================================================
// Module      : tb_led_fade_ctrl
// Description : Scoreboard bench for led_fade_ctrl (FADE_DIV=2, LVL_STEP=100).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_fade_ctrl;

   localparam int W_CNT    = 16;
   localparam int MAX_LVL  = 15;
   localparam int LVL_STEP = 100;
   localparam int FADE_DIV = 2;
   localparam int PWM_DIV  = 1;
   localparam int LW       = 4;
   localparam int PERIOD   = 1000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             btn_up, btn_dn, btn_pwr;
   logic [W_CNT-1:0] period;
   logic [W_CNT-1:0] thr;
   logic             pwm_en;
   logic [LW-1:0]    level;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;
   int mark;

   typedef struct {
      int thr_e;
      int lvl_e;
      int bsy_e;
      int pwm_e;
   } exp_t;
   exp_t exp_q[$];

   led_fade_ctrl #(
      .W_CNT    (W_CNT),
      .MAX_LVL  (MAX_LVL),
      .LVL_STEP (LVL_STEP),
      .FADE_DIV (FADE_DIV),
      .PWM_DIV  (PWM_DIV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_up  (btn_up),
      .btn_dn  (btn_dn),
      .btn_pwr (btn_pwr),
      .period  (period),
      .thr     (thr),
      .pwm_en  (pwm_en),
      .level   (level),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference level->duty map, independent of the DUT.
   function automatic int exp_tgt(input int l);
      int t;
`ifdef LED_FADE_GAMMA_EN
      t = (l * l * LVL_STEP) >> LW;
`else
      t = l * LVL_STEP;
`endif
      return (t > PERIOD) ? PERIOD : t;
   endfunction

   task automatic push_exp(input int thr_e, input int lvl_e, input int bsy_e, input int pwm_e);
      exp_q.push_back('{thr_e, lvl_e, bsy_e, pwm_e});
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      check_val({tag, "_queue"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val({tag, "_thr"},   int'(thr),    e.thr_e);
         check_val({tag, "_level"}, int'(level),  e.lvl_e);
         check_val({tag, "_busy"},  int'(busy),   e.bsy_e);
         check_val({tag, "_pwm"},   int'(pwm_en), e.pwm_e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic u, input logic d, input logic p);
      step();
      btn_up = u; btn_dn = d; btn_pwr = p;
      step();
      btn_up = 1'b0; btn_dn = 1'b0; btn_pwr = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && busy; i++) step();
      check_val({tag, "_settle"}, int'(busy), 0);
   endtask

   task automatic wait_thr_le(input string tag, input int lim, input int budget);
      for (int i = 0; i < budget && (int'(thr) > lim); i++) step();
      check_val({tag, "_reach"}, int'(int'(thr) <= lim), 1);
   endtask

   initial begin
      rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; btn_pwr = 1'b0;
      period = W_CNT'(PERIOD);
      #12;
      push_exp(PERIOD, 7, 0, 0);
      pop_check("reset");
      step();
      rst_n = 1'b1;
      repeat (5) step();
      push_exp(PERIOD, 7, 0, 0);
      pop_check("idle");

      // Power on, ramp rate and final hold at level 7
      press(1'b0, 1'b0, 1'b1);
      check_val("pwr_busy", int'(busy), 1);
      mark = int'(thr);
      repeat (20) step();
      check_val("ramp_rate", mark - int'(thr), 10);
      push_exp(PERIOD - exp_tgt(7), 7, 0, 1);
      wait_idle("on7", 5000);
      pop_check("hold7");

      press(1'b1, 1'b1, 1'b0);
      repeat (5) step();
      push_exp(PERIOD - exp_tgt(7), 7, 0, 1);
      pop_check("up_dn");

      repeat (10) press(1'b1, 1'b0, 1'b0);
      push_exp(PERIOD - exp_tgt(15), 15, 0, 1);
      wait_idle("up_sat", 5000);
      pop_check("lvl15");

      repeat (20) press(1'b0, 1'b1, 1'b0);
      push_exp(PERIOD - exp_tgt(0), 0, 0, 1);
      wait_idle("dn_sat", 5000);
      pop_check("lvl0");

      repeat (7) press(1'b1, 1'b0, 1'b0);
      push_exp(PERIOD - exp_tgt(7), 7, 0, 1);
      wait_idle("back7", 5000);
      pop_check("lvl7");

      // pwr and up together: switch-off wins, level untouched
      press(1'b1, 1'b0, 1'b1);
      check_val("pwrup_busy", int'(busy), 1);
      check_val("pwrup_level", int'(level), 7);
      push_exp(PERIOD, 7, 0, 0);
      wait_idle("pwrup", 5000);
      pop_check("off1");

      // Reverse mid ramp-up
      press(1'b0, 1'b0, 1'b1);
      wait_thr_le("mid", PERIOD - exp_tgt(7) / 2, 5000);
      press(1'b0, 1'b0, 1'b1);
      mark = int'(thr);
      repeat (20) step();
      check_val("reverse_dir", int'(int'(thr) > mark), 1);
      push_exp(PERIOD, 7, 0, 0);
      wait_idle("rev", 5000);
      pop_check("off2");
      repeat (10) step();
      check_val("off_pwm", int'(pwm_en), 0);

      // Resume from zero, then step to level 8
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      repeat (20) step();
      check_val("resume_busy", int'(busy), 1);
      check_val("resume_dir", int'(int'(thr) < PERIOD), 1);
      push_exp(PERIOD - exp_tgt(8), 8, 0, 1);
      wait_idle("lvl8", 5000);
      pop_check("lvl8");

      // Async reset in the middle of a ramp
      press(1'b1, 1'b0, 1'b0);
      repeat (10) step();
      check_val("pre_rst_busy", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      push_exp(PERIOD, 7, 0, 0);
      pop_check("async_rst");
      step();
      rst_n = 1'b1;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
